// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
interface mem_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (output bus_req, bus_we, bus_addr, bus_wdata,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: non-memory ops pass to WB through one register,
// Lw/Sw become stalled, handshaked bus transactions with alignment check and timeout.
module mem_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op_i,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] memData_i,
  input  logic [31:0] regcData_i,
  input  logic        regcWrite_i,
  input  logic [4:0]  regcAddr_i,
  output logic        stall,
  output logic [31:0] regcData,
  output logic        regcWrite,
  output logic [4:0]  regcAddr,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  mem_lsu_if.master   mbus
);
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUS  = 1'b1;

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             is_lw;
  logic             is_sw;
  logic             is_mem;
  logic             misaligned;
  logic             timeout_hit;

  always_comb begin
    is_lw       = (op_i == OP_LW);
    is_sw       = (op_i == OP_SW);
    is_mem      = is_lw | is_sw;
    misaligned  = is_mem & (memAddr_i[1:0] != 2'b00);
    timeout_hit = (state == S_BUS) & (cnt == CNT_LAST);
    stall       = 1'b0;
    // Upstream must not see a stall while reset is asserted.
    if (rst) begin
      if (state == S_IDLE) stall = is_mem & ~misaligned;
      else                 stall = ~mbus.bus_ack & ~timeout_hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      regcData       <= '0;
      regcWrite      <= 1'b0;
      regcAddr       <= '0;
      adel           <= 1'b0;
      ades           <= 1'b0;
      bus_err        <= 1'b0;
      mbus.bus_req   <= 1'b0;
      mbus.bus_we    <= 1'b0;
      mbus.bus_addr  <= '0;
      mbus.bus_wdata <= '0;
    end else begin
      adel    <= 1'b0;
      ades    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!is_mem) begin
            regcData  <= regcData_i;
            regcWrite <= regcWrite_i;
            regcAddr  <= regcAddr_i;
          end else if (misaligned) begin
            regcWrite <= 1'b0;
            adel      <= is_lw;
            ades      <= is_sw;
          end else begin
            state          <= S_BUS;
            cnt            <= '0;
            regcWrite      <= 1'b0;
            mbus.bus_req   <= 1'b1;
            mbus.bus_we    <= is_sw;
            mbus.bus_addr  <= {memAddr_i[31:2], 2'b00};
            mbus.bus_wdata <= memData_i;
          end
        end
        default: begin
          // Ack takes priority over a coinciding timeout.
          if (mbus.bus_ack) begin
            if (!mbus.bus_we) begin
              regcData  <= mbus.bus_rdata;
              regcWrite <= regcWrite_i;
              regcAddr  <= regcAddr_i;
            end else begin
              regcWrite <= 1'b0;
            end
            mbus.bus_req <= 1'b0;
            state        <= S_IDLE;
          end else if (timeout_hit) begin
            regcWrite    <= 1'b0;
            bus_err      <= 1'b1;
            mbus.bus_req <= 1'b0;
            state        <= S_IDLE;
          end else begin
            cnt       <= cnt + 1'b1;
            regcWrite <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit sitting between EX and WB. Consumes EX's `op`, `memAddr`, `memData` and the `regc*` result triple. Non-memory ops pass through with one register stage. `Lw`/`Sw` become handshaked transactions on the data-memory bus, with a pipeline stall, an alignment check and a bus timeout.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of BUS-state cycles waiting for `bus_ack` before the access is aborted (≥2).

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- op_i  in  6  opcode from EX (`Lw`, `Sw` per define.v; anything else is non-memory)
- memAddr_i  in  32  byte address from EX
- memData_i  in  32  store data from EX
- regcData_i  in  32  ALU result from EX
- regcWrite_i  in  1  write-enable from EX
- regcAddr_i  in  5  destination register from EX
- stall  out  1  combinational; EX/upstream must hold all inputs while high
- regcData  out  32  registered result to WB
- regcWrite  out  1  registered write-enable to WB
- regcAddr  out  5  registered destination to WB
- bus_req  out  1  registered request, held until ack or abort
- bus_we  out  1  1 = store, 0 = load; valid with bus_req
- bus_addr  out  32  word address (low 2 bits always 0)
- bus_wdata  out  32  store data
- bus_rdata  in  32  load data, sampled in the cycle bus_ack=1
- bus_ack  in  1  transaction complete
- adel  out  1  one-cycle pulse: misaligned load
- ades  out  1  one-cycle pulse: misaligned store
- bus_err  out  1  one-cycle pulse: timeout abort

## Operation
- States: IDLE, BUS.
- IDLE, non-memory op: at the edge, `regcData`/`regcWrite`/`regcAddr` ← `_i` values; stall=0.
- IDLE, `Lw`/`Sw` with `memAddr_i[1:0]≠0`: stall=0; no bus activity. At the edge, `regcWrite`←0 and `adel` (Lw) or `ades` (Sw) pulses for one cycle.
- IDLE, aligned `Lw`/`Sw`: stall=1. At the edge:
  - state→BUS, bus_req←1
  - bus_we←(op==Sw), bus_addr←memAddr_i, bus_wdata←memData_i
  - timeout counter←0
  - output regs take a bubble: regcWrite←0.
- BUS: bus_req/bus_we/bus_addr/bus_wdata stay stable; stall = ~bus_ack & ~timeout_hit.
  - bus_ack=1 (completion) at the edge:
    - Lw: regcData←bus_rdata, regcWrite←regcWrite_i, regcAddr←regcAddr_i
    - Sw: regcWrite←0
    - bus_req←0, state→IDLE
  - Else the counter increments. When counter==TIMEOUT-1 without ack (timeout_hit), stall=0 and at the edge: bus_req←0, regcWrite←0, bus_err pulses, state→IDLE.
  - If ack and timeout_hit coincide, ack wins (normal completion, no bus_err).
- Any other BUS cycle: output regs hold, except regcWrite←0 (bubble).
- Store never writes a register, regardless of regcWrite_i.
- Reset (rst=0, any time, including mid-BUS): state→IDLE and all registered outputs 0. bus_req drops asynchronously, and the in-flight access is abandoned.

## Timing
- Reset values: regcData=0, regcWrite=0, regcAddr=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, adel=0, ades=0, bus_err=0, counter=0. stall=0 while in reset.
- Non-memory op latency: 1 cycle to WB outputs, zero stall.
- Aligned access with ack on the first BUS cycle:
  - cycle 0: accept, stall=1
  - cycle 1: bus_req=1, ack, stall=0
  - WB outputs valid after the cycle-1 edge
  - total 2 cycles, 1 stall cycle.
- Each extra wait cycle adds one stall cycle.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle after completion. bus_req is low for at least one cycle between transactions.
- Maximum BUS residency is TIMEOUT cycles.

## Test plan
- Reset mid-transaction: Lw 0x100 issued, rst low during BUS → bus_req drops immediately; all outputs 0; IDLE after release; no WB write.
- `Add` with regcData_i=0x5, regcAddr_i=3, regcWrite_i=1 → next cycle regcData=0x5, regcAddr=3, regcWrite=1; stall never high.
- Aligned Lw to 0x0000_0010, regcAddr_i=8, bus_ack after 3 wait cycles with rdata=0xDEAD_BEEF:
  - bus_req high 4 cycles, bus_we=0, bus_addr=0x10
  - stall high exactly 4 cycles
  - then regcData=0xDEADBEEF, regcAddr=8, regcWrite=1.
- Sw 0x0000_0020 data 0x1234_5678, ack on first BUS cycle → bus_we=1, bus_wdata=0x12345678 for 1 cycle; stall 1 cycle; regcWrite=0.
- Lw to 0x0000_0013 → adel pulses 1 cycle, no bus_req, stall=0, regcWrite=0. Sw to 0x2 → ades pulses the same way.
- TIMEOUT=16, Lw with bus_ack tied 0 → bus_req high 16 cycles, then bus_err pulses once, regcWrite=0, stall releases. Repeat with ack arriving exactly on the 16th cycle → normal completion, no bus_err.
